// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM state encoding, access-size codes
// and the alignment rule used at request accept.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size code 2'b11 falls into the default branch and is checked as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return byte_off[0];
      default: return byte_off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word
// and merges sub-word store data into the word read back from memory.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = mem_rdata_i[{byte_off_i, 3'b000} +: 8];
  assign lane_h = mem_rdata_i[{byte_off_i[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_data_o  = mem_rdata_i;
    merge_data_o = mem_rdata_i;
    case (size_i)
      SIZE_B: begin
        load_data_o = {{24{~is_unsigned_i & lane_b[7]}}, lane_b};
        merge_data_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_data_o = {{16{~is_unsigned_i & lane_h[15]}}, lane_h};
        merge_data_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o  = mem_rdata_i;
        merge_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> [WRITE] -> RESP, with
// read-modify-write for sub-word stores and an early fault path for misalignment.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;
  logic              store_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;
  logic              mis_q;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        word_store;
  logic        mem_active;

  lsu_lane_align u_lane_align (
    .size_i        (size_q),
    .is_unsigned_i (unsigned_q),
    .byte_off_i    (addr_q[1:0]),
    .mem_rdata_i   (mem_rdata),
    .wdata_i       (wdata_q),
    .load_data_o   (load_data),
    .merge_data_o  (merge_data)
  );

  // Sizes 10 and 11 are both full-word accesses.
  assign word_store = store_q & size_q[1];
  assign mem_active = (state_q == ACCESS) || (state_q == WRITE);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      merge_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q    <= req_store;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            mis_q      <= is_misaligned(req_size, req_addr[1:0]);
            state_q    <= is_misaligned(req_size, req_addr[1:0]) ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!store_q) begin
            rdata_q <= load_data;
            state_q <= RESP;
          end else if (!word_store) begin
            merge_q <= merge_data;
            state_q <= WRITE;
          end else begin
            state_q <= RESP;
          end
        end
        WRITE:   state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes decode the state register only, so reset drops them at once.
  assign mem_we    = (state_q == WRITE) || ((state_q == ACCESS) && word_store);
  assign mem_wdata = (state_q == WRITE)                    ? merge_q :
                     ((state_q == ACCESS) && word_store)   ? wdata_q : '0;
  assign mem_addr  = mem_active ? {2'b00, addr_q[ADDR_W-1:2]} : '0;

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_rdata      = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and
// hand-computed expected results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  logic        tb_wr_en;
  logic [3:0]  tb_wr_idx;
  logic [31:0] tb_wr_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    else if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_val;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    tb_wr_en  = 1'b1;
    tb_wr_idx = idx;
    tb_wr_val = val;
    @(negedge clk);
    tb_wr_en  = 1'b0;
  endtask

  // Issues one request and observes it until resp_valid (bounded to 8 cycles);
  // lat = cycles after the accept edge, 99 if no response arrived.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic mis,
                        output int we_cnt, output logic [31:0] we_data,
                        output logic [31:0] we_addr);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    lat = 99; rdata = '0; mis = 1'b0; we_cnt = 0; we_data = '0; we_addr = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        check("ready_busy", 32'(req_ready), 32'd0);
      end
      if (mem_we) begin
        we_cnt++;
        we_data = mem_wdata;
        we_addr = mem_addr;
      end
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
        mis   = resp_misaligned;
        break;
      end
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  int          lat, we_cnt, rcnt, nacc;
  int          acc [4];
  logic [31:0] rdata, we_data, we_addr;
  logic        mis;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    tb_wr_en = 1'b0; tb_wr_idx = '0; tb_wr_val = '0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_misaligned", 32'(resp_misaligned), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    poke(4'd0, 32'h0000_4430);
    poke(4'd1, 32'h0000_8610);

    // lb 0x1
    do_req(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lb_data", rdata, 32'h0000_0044);
    check("lb_lat", lat, 2);
    check("lb_no_we", we_cnt, 0);
    check("lb_mis", 32'(mis), 32'd0);
    // lh / lhu 0x4
    do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lh_data", rdata, 32'hFFFF_8610);
    check("lh_lat", lat, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lhu_data", rdata, 32'h0000_8610);
    // lb 0x5 sign-extends 0x86, lbu 0x0 zero-extends 0x30, lw 0x4
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lb_neg_data", rdata, 32'hFFFF_FF86);
    do_req(1'b0, 2'b00, 1'b1, 32'h0, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lbu_data", rdata, 32'h0000_0030);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lw_data", rdata, 32'h0000_8610);

    // sb 0xAB at 0x2
    do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h1234_56AB, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("sb_we_cnt", we_cnt, 1);
    check("sb_wdata", we_data, 32'h00AB_4430);
    check("sb_waddr", we_addr, 32'h0);
    check("sb_lat", lat, 3);
    check("sb_rdata", rdata, 32'h0);
    check("sb_mem", mem[0], 32'h00AB_4430);
    // sh 0xCDEF at 0x6
    do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_CDEF, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("sh_wdata", we_data, 32'hCDEF_8610);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[1], 32'hCDEF_8610);

    // misaligned sw 0x6 and lh 0x3
    do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFF_FFFF, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("sw_mis_flag", 32'(mis), 32'd1);
    check("sw_mis_rdata", rdata, 32'h0);
    check("sw_mis_no_we", we_cnt, 0);
    check("sw_mis_lat", lat, 1);
    check("sw_mis_mem", mem[1], 32'hCDEF_8610);
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("lh_mis_flag", 32'(mis), 32'd1);
    check("lh_mis_lat", lat, 1);

    // sw 0x8, then size 11 treated as word
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("sw_we_cnt", we_cnt, 1);
    check("sw_wdata", we_data, 32'hDEAD_BEEF);
    check("sw_waddr", we_addr, 32'h2);
    check("sw_lat", lat, 2);
    check("sw_mem", mem[2], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, lat, rdata, mis, we_cnt, we_data, we_addr);
    check("l11_data", rdata, 32'hDEAD_BEEF);
    check("l11_mis", 32'(mis), 32'd0);

    // back-to-back loads with req_valid held high
    @(negedge clk);
    req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h1;
    req_valid = 1'b1;
    nacc = 0; rcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready && nacc < 4) begin
        acc[nacc] = c;
        nacc++;
      end
      if (resp_valid) rcnt++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", nacc, 4);
    check("b2b_gap0", acc[1] - acc[0], 3);
    check("b2b_gap1", acc[2] - acc[1], 3);
    check("b2b_resps", rcnt, 4);

    // reset while in WRITE
    poke(4'd3, 32'h1122_3344);
    @(negedge clk);
    req_store = 1'b1; req_size = 2'b00; req_addr = 32'hC; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("wr_we_before_rst", 32'(mem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_we_async", 32'(mem_we), 32'd0);
    check("rst_wdata_async", mem_wdata, 32'h0);
    check("rst_addr_async", mem_addr, 32'h0);
    check("rst_ready_async", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_kept", mem[3], 32'h1122_3344);
    reset_n = 1'b1;
    rcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) rcnt++;
    end
    check("rst_no_resp", rcnt, 0);
    check("rst_mem_final", mem[3], 32'h1122_3344);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
